// File: rtl/keypad_scan_if.sv
// Keypad scanner signal bundle: row drive / column sense toward the matrix,
// key code and strobes toward the consumer.
// Handshake: key_valid is a one-cycle strobe with no ready/backpressure; the
// consumer must take key on the cycle key_valid is high. key stays valid
// afterwards until the next strobe. key_down is a level, not a handshake.
interface keypad_scan_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key;
  logic       key_valid;
  logic       key_down;
  logic [1:0] dbg_state;

  modport master (
    output row, key, key_valid, key_down, dbg_state,
    input  col
  );

  modport slave (
    input  row, key, key_valid, key_down, dbg_state,
    output col
  );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with full-scan debounce.
// One row is driven low per SCAN_DIV-clock slot; columns are sampled on the
// slot's last clock. Each complete scan (rows 0..3) yields NONE, SINGLE(code)
// or MULTI, registered for one clock and then fed to the debounce FSM.
module keypad_scan #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic         clk,
  input  logic         rst,
  keypad_scan_if.master kp
);

  localparam int              DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_N    = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    ST_IDLE, ST_PRESS_WAIT, ST_HELD, ST_RELEASE_WAIT
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE, RES_SINGLE, RES_MULTI
  } res_t;

  // Row r, column c to hex key code.
  function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  logic [3:0]       col_s1_q, col_s2_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       row_idx_q;
  logic [3:0]       row_q;
  logic [1:0]       hits_q, hits_d;     // 0, 1, or 2 meaning "two or more"
  logic [3:0]       code_q, code_d;     // code of the first hit this scan
  res_t             kind_d;
  logic             res_valid_q;
  res_t             res_kind_q;
  logic [3:0]       res_code_q;
  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [3:0]       cand_q;
  logic [3:0]       key_q;
  logic             key_valid_q;
  logic             key_down_q;
  logic             slot_end;

  assign slot_end = (div_q == DIV_LAST);

  // Fold the current row's synchronised column sample into the scan accumulator.
  always_comb begin
    hits_d = hits_q;
    code_d = code_q;
    for (int c = 0; c < 4; c++) begin
      if (!col_s2_q[c]) begin
        if (hits_d == 2'd0) code_d = key_code(row_idx_q, 2'(c));
        if (hits_d != 2'd2) hits_d = hits_d + 2'd1;
      end
    end
    case (hits_d)
      2'd0:    kind_d = RES_NONE;
      2'd1:    kind_d = RES_SINGLE;
      default: kind_d = RES_MULTI;
    endcase
  end

  // Column synchroniser, slot divider, row rotation and per-scan result register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      col_s1_q    <= 4'hF;
      col_s2_q    <= 4'hF;
      div_q       <= '0;
      row_idx_q   <= 2'd0;
      row_q       <= 4'b1110;
      hits_q      <= 2'd0;
      code_q      <= 4'h0;
      res_valid_q <= 1'b0;
      res_kind_q  <= RES_NONE;
      res_code_q  <= 4'h0;
    end else begin
      col_s1_q    <= kp.col;
      col_s2_q    <= col_s1_q;
      res_valid_q <= 1'b0;
      if (slot_end) begin
        div_q     <= '0;
        row_idx_q <= row_idx_q + 2'd1;
        row_q     <= {row_q[2:0], row_q[3]};
        if (row_idx_q == 2'd3) begin
          res_valid_q <= 1'b1;
          res_kind_q  <= kind_d;
          res_code_q  <= code_d;
          hits_q      <= 2'd0;
          code_q      <= 4'h0;
        end else begin
          hits_q <= hits_d;
          code_q <= code_d;
        end
      end else begin
        div_q <= div_q + DIV_W'(1);
      end
    end
  end

  // Debounce FSM, stepped once per registered scan result; outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      cand_q      <= 4'h0;
      key_q       <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (res_valid_q) begin
        case (state_q)
          ST_IDLE: begin
            if (res_kind_q == RES_SINGLE) begin
              cand_q <= res_code_q;
              cnt_q  <= 4'd1;
              if (DEB_N == 4'd1) begin
                key_q       <= res_code_q;
                key_valid_q <= 1'b1;
                key_down_q  <= 1'b1;
                state_q     <= ST_HELD;
              end else begin
                state_q <= ST_PRESS_WAIT;
              end
            end
          end
          ST_PRESS_WAIT: begin
            if (res_kind_q == RES_SINGLE) begin
              if (res_code_q == cand_q) begin
                cnt_q <= cnt_q + 4'd1;
                if (cnt_q + 4'd1 == DEB_N) begin
                  key_q       <= cand_q;
                  key_valid_q <= 1'b1;
                  key_down_q  <= 1'b1;
                  state_q     <= ST_HELD;
                end
              end else begin
                cand_q <= res_code_q;
                cnt_q  <= 4'd1;
              end
            end else begin
              cnt_q   <= 4'd0;
              state_q <= ST_IDLE;
            end
          end
          ST_HELD: begin
            // A different key or a second key while held is ignored until release.
            if (res_kind_q == RES_NONE) begin
              cnt_q <= 4'd1;
              if (DEB_N == 4'd1) begin
                key_down_q <= 1'b0;
                state_q    <= ST_IDLE;
              end else begin
                state_q <= ST_RELEASE_WAIT;
              end
            end
          end
          default: begin
            if (res_kind_q == RES_NONE) begin
              cnt_q <= cnt_q + 4'd1;
              if (cnt_q + 4'd1 == DEB_N) begin
                key_down_q <= 1'b0;
                state_q    <= ST_IDLE;
              end
            end else begin
              state_q <= ST_HELD;
            end
          end
        endcase
      end
    end
  end

  assign kp.row       = row_q;
  assign kp.key       = key_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_down  = key_down_q;
  assign kp.dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a switch-matrix model drives col from row, a
// reference model predicts every output each cycle, and directed scenarios
// pin pulse timing and key codes with hand-computed values.
module tb_keypad_scan;
  localparam int SD   = 4;
  localparam int DS   = 3;
  localparam int SCAN = 4 * SD;

  localparam logic [3:0] KEYMAP [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };
  localparam logic [3:0] ROW_TAB [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  logic clk = 1'b0;
  logic rst = 1'b0;

  keypad_scan_if kp_if ();

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp_if.master)
  );

  // Clock
  always #5 clk = ~clk;

  // Switch matrix: pressed key (r,c) pulls column c low while row r is driven low.
  logic [15:0] keys    = 16'h0;
  logic        contact = 1'b1;
  always_comb begin
    kp_if.col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && contact && !kp_if.row[r]) kp_if.col[c] = 1'b0;
  end

  int checks = 0;
  int errors = 0;
  int edge_n = 0;
  int since_rst = 0;

  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    since_rst <= (!rst) ? 0 : since_rst + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: predicts outputs after the next edge from the spec's rules.
  bit         m_ok = 0;
  int         m_t;
  logic [3:0] m_s1, m_s2;
  logic [3:0] m_samp [4];
  bit         m_pend;
  int         m_pkind;     // 0 none, 1 single, 2 multi
  logic [3:0] m_pcode;
  bit         m_held;
  int         m_run;
  logic [3:0] m_last_code;
  logic [3:0] exp_key, exp_row;
  logic       exp_valid, exp_down;

  always @(negedge clk) begin
    if (m_ok) begin
      check("row",       kp_if.row,       exp_row);
      check("key",       kp_if.key,       exp_key);
      check("key_valid", kp_if.key_valid, exp_valid);
      check("key_down",  kp_if.key_down,  exp_down);
    end
    if (!rst) begin
      m_ok = 1; m_t = 0; m_s1 = 4'hF; m_s2 = 4'hF; m_pend = 0;
      m_held = 0; m_run = 0; m_last_code = 4'h0;
      exp_key = 4'h0; exp_valid = 1'b0; exp_down = 1'b0;
    end else if (m_ok) begin
      exp_valid = 1'b0;
      if (m_pend) begin
        if (!m_held) begin
          if (m_pkind == 1) begin
            if (m_run > 0 && m_pcode == m_last_code) m_run++;
            else m_run = 1;
            m_last_code = m_pcode;
          end else begin
            m_run = 0;
          end
          if (m_run == DS) begin
            exp_key = m_last_code; exp_valid = 1'b1; exp_down = 1'b1;
            m_held = 1; m_run = 0;
          end
        end else begin
          if (m_pkind == 0) m_run++;
          else m_run = 0;
          if (m_run == DS) begin
            exp_down = 1'b0; m_held = 0; m_run = 0;
          end
        end
      end
      m_pend = 0;
      if (m_t % SD == SD - 1) begin
        m_samp[(m_t / SD) % 4] = m_s2;
        if ((m_t / SD) % 4 == 3) begin
          int n;
          n = 0;
          for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
              if (!m_samp[r][c]) begin
                n++;
                m_pcode = KEYMAP[r*4+c];
              end
          m_pkind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
          m_pend = 1;
        end
      end
      m_s2 = m_s1;
      m_s1 = kp_if.col;
      m_t = (m_t + 1) % SCAN;
    end
    exp_row = 4'hF;
    exp_row[(m_t / SD) % 4] = 1'b0;
  end

  // Pulse / release monitor for the directed scenarios.
  int         pulse_cnt = 0;
  int         fall_cnt = 0;
  int         last_pulse_edge = -1;
  int         last_fall_edge = -1;
  logic [3:0] last_pulse_key = 4'h0;
  logic       prev_down = 1'b0;
  always @(negedge clk) begin
    if (kp_if.key_valid === 1'b1) begin
      pulse_cnt++;
      last_pulse_edge = edge_n;
      last_pulse_key = kp_if.key;
    end
    if (prev_down === 1'b1 && kp_if.key_down === 1'b0) begin
      fall_cnt++;
      last_fall_edge = edge_n;
    end
    prev_down = kp_if.key_down;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Advance to just after the edge that starts a new scan (row 0, divider 0).
  task automatic wait_boundary();
    for (int i = 0; i < SCAN + 1; i++) begin
      step(1);
      if (since_rst % SCAN == 0) break;
    end
  endtask

  task automatic bounce(input int toggles);
    for (int i = 0; i < toggles; i++) begin
      contact = ~contact;
      step(5);
    end
  endtask

  int b_edge, p0, f0;

  initial begin
    // Reset and idle scanning
    rst = 1'b0;
    step(3);
    check("reset_row",   kp_if.row, 4'hE);
    check("reset_key",   kp_if.key, 4'h0);
    check("reset_valid", kp_if.key_valid, 1'b0);
    check("reset_down",  kp_if.key_down, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      check("idle_row", kp_if.row, ROW_TAB[(i / 4) % 4]);
      check("idle_outs", {kp_if.key, kp_if.key_valid, kp_if.key_down}, 6'h0);
      step(1);
    end

    // Key 5, clean press from a scan boundary
    wait_boundary();
    b_edge = edge_n; p0 = pulse_cnt;
    keys[1*4+1] = 1'b1;
    step(5 * SCAN);
    check("k5_pulses", pulse_cnt - p0, 1);
    check("k5_latency", last_pulse_edge, b_edge + 3 * SCAN + 1);
    check("k5_key", last_pulse_key, 4'h5);
    check("k5_down", kp_if.key_down, 1'b1);
    wait_boundary();
    b_edge = edge_n; p0 = pulse_cnt; f0 = fall_cnt;
    keys = 16'h0;
    step(5 * SCAN);
    check("k5_rel_fall", fall_cnt - f0, 1);
    check("k5_rel_latency", last_fall_edge, b_edge + 3 * SCAN + 1);
    check("k5_rel_pulses", pulse_cnt - p0, 0);
    check("k5_rel_key", kp_if.key, 4'h5);

    // Hold '0' for 20 scans, then add '#'
    p0 = pulse_cnt; f0 = fall_cnt;
    keys[3*4+1] = 1'b1;
    step(20 * SCAN);
    keys[3*4+2] = 1'b1;
    step(5 * SCAN);
    check("k0_pulses", pulse_cnt - p0, 1);
    check("k0_key", last_pulse_key, 4'h0);
    check("k0_down_held", kp_if.key_down, 1'b1);
    check("k0_no_fall", fall_cnt - f0, 0);
    keys = 16'h0;
    step(6 * SCAN);
    check("k0_rel_down", kp_if.key_down, 1'b0);
    check("k0_rel_fall", fall_cnt - f0, 1);
    check("k0_rel_pulses", pulse_cnt - p0, 1);

    // 'A' with bounce on press and release
    p0 = pulse_cnt; f0 = fall_cnt;
    keys[0*4+3] = 1'b1; contact = 1'b1;
    bounce(8);
    contact = 1'b1;
    step(6 * SCAN);
    check("kA_pulses", pulse_cnt - p0, 1);
    check("kA_key", kp_if.key, 4'hA);
    check("kA_down", kp_if.key_down, 1'b1);
    p0 = pulse_cnt;
    contact = 1'b0;
    bounce(8);
    keys = 16'h0; contact = 1'b1;
    step(6 * SCAN);
    check("kA_rel_pulses", pulse_cnt - p0, 0);
    check("kA_rel_fall", fall_cnt - f0, 1);
    check("kA_rel_down", kp_if.key_down, 1'b0);

    // 1 and 2 together: MULTI, never accepted
    p0 = pulse_cnt;
    keys[0] = 1'b1; keys[1] = 1'b1;
    step(10 * SCAN);
    check("multi_pulses", pulse_cnt - p0, 0);
    check("multi_down", kp_if.key_down, 1'b0);
    check("multi_key", kp_if.key, 4'hA);
    keys = 16'h0;
    step(2 * SCAN);

    // Key 9 with a reset mid-debounce
    wait_boundary();
    p0 = pulse_cnt;
    keys[2*4+2] = 1'b1;
    step(2 * SCAN + 4);
    check("k9_pre_pulses", pulse_cnt - p0, 0);
    rst = 1'b0;
    step(1);
    b_edge = edge_n;
    check("k9_rst_row", kp_if.row, 4'hE);
    check("k9_rst_outs", {kp_if.key, kp_if.key_valid, kp_if.key_down}, 6'h0);
    rst = 1'b1;
    step(4 * SCAN);
    check("k9_pulses", pulse_cnt - p0, 1);
    check("k9_latency", last_pulse_edge, b_edge + 3 * SCAN + 1);
    check("k9_key", last_pulse_key, 4'h9);
    keys = 16'h0;
    step(5 * SCAN);
    check("k9_rel_down", kp_if.key_down, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Input-side counterpart to the multiplexed 7-segment display driver: scans a 4x4 active-low matrix keypad and debounces it.
- Drives one row low at a time and samples the columns.
- Emits a 4-bit hex key code with a one-cycle valid strobe, sized to feed a counter or display value directly.
- Sits on the board clock beside the display driver. No other clock domain.

Parameters:
- SCAN_DIV, 50000, clocks each row is held driven (0.5 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-scan results needed to accept a press or a release; range 1..15.

Ports:
- clk  input  1  board clock.
- rst  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- row  output 4  row drive, active-low, exactly one bit low at all times.
- col  input  4  column sense, active-low, externally pulled up, asynchronous.
- key  output 4  hex code of last accepted key.
- key_valid  output 1  one-cycle pulse when a press is accepted.
- key_down  output 1  high while the accepted key is considered held.

Behaviour:
- Reset (rst=0 at a clk edge):
  - row=4'b1110, key=0, key_valid=0, key_down=0.
  - Divider, row index, scan accumulator, debounce count and FSM all cleared.
  - FSM goes to IDLE.
  - Reset mid-press gives no pulse; the key must be re-accepted from IDLE.
- col synchronisation: two-flop synchroniser. The samples used are the synchronised values.
- Scan timing:
  - Divider counts 0..SCAN_DIV-1 per row slot. Row index r steps 0->1->2->3->0 when the divider wraps.
  - row = ~(1<<r).
  - Columns for row r are sampled on the last clock of the slot (divider = SCAN_DIV-1), giving the synchroniser at least SCAN_DIV-1 cycles to settle.
- Scan result:
  - A full scan covers rows 0..3. The result is produced on the clock the row 3 sample is taken.
  - NONE: no column low on any row.
  - SINGLE(code): exactly one row/col intersection low.
  - MULTI: two or more low.
- Key map, row r col c -> code:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- Debounce FSM, evaluated once per scan result:
  - IDLE: SINGLE(k) -> cand=k, cnt=1 -> PRESS_WAIT; if DEBOUNCE_SCANS=1, accept immediately. NONE/MULTI -> stay.
  - PRESS_WAIT:
    - SINGLE(cand) -> cnt++. When cnt reaches DEBOUNCE_SCANS: accept -> HELD.
    - SINGLE(other) -> cand=other, cnt=1.
    - NONE or MULTI -> IDLE.
  - HELD:
    - NONE -> cnt=1 -> RELEASE_WAIT.
    - SINGLE/MULTI (any key, including a different one) -> stay; no new acceptance until release.
  - RELEASE_WAIT:
    - NONE -> cnt++. At DEBOUNCE_SCANS -> IDLE, key_down=0.
    - Anything else -> HELD.
- Accept action:
  - key=cand and key_valid=1 on the clock after the accepting scan result. Pulse is exactly one cycle.
  - key_down=1 on the same clock.
- key holds its value until the next acceptance; it is not cleared on release.
- Latency from the first clean scan of a stable press to key_valid: DEBOUNCE_SCANS scans plus 1 clock.
- Counters are wide enough for their parameters; no wrap occurs inside a state.
- Scanning continues unconditionally in all states.

Test Plan:
- Use SCAN_DIV=4, DEBOUNCE_SCANS=3 (one scan = 16 clocks) for all scenarios.
- Reset then free-run 32 clocks, no key pressed:
  - row = 1110,1101,1011,0111 for 4 clocks each, repeating.
  - key=0, key_valid and key_down stay 0.
- Model key 5 (col[1] low while row[1] low), held stable from a scan boundary:
  - Exactly one key_valid pulse, 3 scans + 1 clock after the boundary.
  - key=4'h5, key_down=1.
  - After release, key_down falls 3 scans + 1 clock after the first NONE scan; key stays 4'h5.
- Press 'A' with bounce (toggle every 5 clocks for 40 clocks), then hold 6 scans:
  - Exactly one pulse, key=4'hA.
  - Release with the same bounce: no pulse, key_down falls once.
- Hold '0' for 20 scans, then press '#' too while held:
  - Single pulse with key=4'h0.
  - No further pulse; key_down stays 1 until both are released.
- Press 1 and 2 together from IDLE for 10 scans (MULTI): no pulse, key_down=0.
- Press 9, assert rst=0 for one clock mid-PRESS_WAIT, keep 9 held:
  - Outputs reset to 0.
  - Pulse with key=4'h9 occurs 3 full scans after reset release.
